cpu_pipe: RTL and testbench

//  Parametrised two-stage (fetch/execute) successor to the single-cycle cpu core. Same 16-bit

---
 rtl/cpu_pipe.sv | 155 +++++++++++++++
 tb/tb_cpu_pipe.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cpu_pipe.sv
// Two-stage fetch/execute core: 16-bit instructions, 16 registers,
// stalling fetch handshake, branch flush, halt/resume and debug read port.
module cpu_pipe #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              clear,
    output logic [ADDR_W-1:0] ins_addr,
    output logic              ins_req,
    input  logic [15:0]       ins,
    input  logic              ins_valid,
    input  logic              resume,
    output logic              halted,
    output logic              retire,
    input  logic [3:0]        dbg_sel,
    output logic [WIDTH-1:0]  dbg_data
);

    typedef enum logic {RUN, HALT} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] pc, ir_pc;
    logic [15:0]       ir;
    logic              ir_valid;
    logic [WIDTH-1:0]  regs [16];

    logic [3:0]         op, d, s1, s2;
    logic [WIDTH-1:0]   a, b, cur, pc_ext, link_val;
    logic [2*WIDTH-1:0] prod_u, prod_s;
    logic               exec_ok, accept;
    logic               wr_en, hi_en, link_en, redir, go_halt;
    logic [WIDTH-1:0]   wr_val, hi_val;
    logic [ADDR_W-1:0]  target;

    assign op = ir[15:12];
    assign d  = ir[11:8];
    assign s1 = ir[7:4];
    assign s2 = ir[3:0];

    // Inside E, r15 is the address of the instruction being executed
    assign pc_ext   = WIDTH'(ir_pc);
    assign a        = (s1 == 4'h0) ? '0 : (s1 == 4'hF) ? pc_ext : regs[s1];
    assign b        = (s2 == 4'h0) ? '0 : (s2 == 4'hF) ? pc_ext : regs[s2];
    assign cur      = (d == 4'h0) ? '0 : (d == 4'hF) ? pc_ext : regs[d];
    assign link_val = pc_ext + {{(WIDTH-1){1'b0}}, 1'b1};

    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

    assign ins_req  = (state == RUN) & ~clear;
    assign ins_addr = pc;
    assign accept   = ins_req & ins_valid;
    assign exec_ok  = ir_valid & (state == RUN);
    assign retire   = exec_ok;
    assign halted   = (state == HALT);

    assign dbg_data = (dbg_sel == 4'h0) ? '0 :
                      (dbg_sel == 4'hF) ? WIDTH'(pc) : regs[dbg_sel];

    always_comb begin
        wr_en   = 1'b0;
        wr_val  = '0;
        hi_en   = 1'b0;
        hi_val  = '0;
        link_en = 1'b0;
        redir   = 1'b0;
        target  = '0;
        go_halt = 1'b0;
        if (exec_ok) begin
            case (op)
                4'h0: wr_en = 1'b1;
                4'h1: begin wr_en = 1'b1; wr_val = a + b; end
                4'h2: begin wr_en = 1'b1; wr_val = a - b; end
                4'h3: begin
                    wr_en  = 1'b1;
                    wr_val = prod_u[WIDTH-1:0];
                    hi_en  = 1'b1;
                    hi_val = prod_u[2*WIDTH-1:WIDTH];
                end
                4'h4: begin wr_en = 1'b1; wr_val = a & b; end
                4'h5: begin wr_en = 1'b1; wr_val = a | b; end
                4'h6: begin wr_en = 1'b1; wr_val = a ^ b; end
                4'h7: begin
                    wr_en  = 1'b1;
                    wr_val = prod_s[WIDTH-1:0];
                    hi_en  = 1'b1;
                    hi_val = prod_s[2*WIDTH-1:WIDTH];
                end
                4'h8: begin wr_en = 1'b1; wr_val = a << b; end
                4'h9: begin wr_en = 1'b1; wr_val = a >> b; end
                4'hA: if (b == '0) begin wr_en = 1'b1; wr_val = a; end
                4'hB: if (b != '0) begin wr_en = 1'b1; wr_val = a; end
                4'hC: begin
                    redir   = 1'b1;
                    target  = a[ADDR_W-1:0];
                    link_en = 1'b1;
                end
                4'hD: go_halt = 1'b1;
                4'hE: begin wr_en = 1'b1; wr_val = WIDTH'(ir[7:0]); end
                default: begin
                    wr_en        = 1'b1;
                    wr_val       = cur;
                    wr_val[15:8] = ir[7:0];
                end
            endcase
            if (wr_en && d == 4'hF) begin
                redir  = 1'b1;
                target = wr_val[ADDR_W-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (go_halt) state_nx = HALT;
            default: if (resume) state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state    <= RUN;
            pc       <= ADDR_W'(RESET_PC);
            ir_pc    <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            // Halt and redirect both squash the fetch accepted this cycle
            if (go_halt) begin
                pc       <= ir_pc + ADDR_W'(1);
                ir_valid <= 1'b0;
            end else if (redir) begin
                pc       <= target;
                ir_valid <= 1'b0;
            end else if (accept) begin
                ir       <= ins;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
                pc       <= pc + ADDR_W'(1);
            end else begin
                ir_valid <= 1'b0;
            end
            if (wr_en && d != 4'h0 && d != 4'hF) regs[d] <= wr_val;
            if (hi_en) regs[8] <= hi_val;
            if (link_en) regs[4] <= link_val;
        end
    end

endmodule

// File: tb/tb_cpu_pipe.sv
// Directed bench for cpu_pipe: cycle table over a small ROM program,
// then a hand-written clear-during-wait sequence.
module tb_cpu_pipe;

    logic        clk;
    logic        clear;
    logic [15:0] ins_addr;
    logic        ins_req;
    logic [15:0] ins;
    logic        ins_valid;
    logic        resume;
    logic        halted;
    logic        retire;
    logic [3:0]  dbg_sel;
    logic [15:0] dbg_data;

    logic [15:0] rom [256];

    int total = 0;
    int bad   = 0;

    cpu_pipe #(.WIDTH(16), .ADDR_W(16), .RESET_PC(0)) dut (
        .clk       (clk),
        .clear     (clear),
        .ins_addr  (ins_addr),
        .ins_req   (ins_req),
        .ins       (ins),
        .ins_valid (ins_valid),
        .resume    (resume),
        .halted    (halted),
        .retire    (retire),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ins = rom[ins_addr[7:0]];

    typedef struct {
        logic        v;
        logic        rs;
        logic [3:0]  sel;
        logic [15:0] addr;
        logic        req;
        logic        ret;
        logic        hlt;
        logic [15:0] dbg;
    } vec_t;

    vec_t vt [24];

    task automatic chk(input string name, input int cyc,
                       input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'hE3FF;
        rom[8'h00] = 16'hE112;
        rom[8'h01] = 16'hF134;
        rom[8'h02] = 16'hE210;
        rom[8'h03] = 16'hAF20;
        rom[8'h05] = 16'hE600;
        rom[8'h06] = 16'hF680;
        rom[8'h07] = 16'h3866;
        rom[8'h08] = 16'hD000;
        rom[8'h09] = 16'h1716;
        rom[8'h0A] = 16'h2971;
        rom[8'h0B] = 16'h7A16;
        rom[8'h10] = 16'hE505;
        rom[8'h11] = 16'hBF50;
        rom[8'h12] = 16'hC050;

        //          v  rs sel  addr      req ret hlt dbg
        vt[0]  = '{1, 0, 15, 16'h0000, 1, 0, 0, 16'h0000};
        vt[1]  = '{1, 0,  1, 16'h0001, 1, 1, 0, 16'h0000};
        vt[2]  = '{1, 0,  1, 16'h0002, 1, 1, 0, 16'h0012};
        vt[3]  = '{1, 0,  1, 16'h0003, 1, 1, 0, 16'h3412};
        vt[4]  = '{1, 0,  2, 16'h0004, 1, 1, 0, 16'h0010};
        vt[5]  = '{1, 0, 15, 16'h0010, 1, 0, 0, 16'h0010};
        vt[6]  = '{1, 0,  3, 16'h0011, 1, 1, 0, 16'h0000};
        vt[7]  = '{1, 0,  5, 16'h0012, 1, 1, 0, 16'h0005};
        vt[8]  = '{1, 0,  5, 16'h0013, 1, 1, 0, 16'h0005};
        vt[9]  = '{1, 0,  4, 16'h0005, 1, 0, 0, 16'h0013};
        vt[10] = '{1, 0, 15, 16'h0006, 1, 1, 0, 16'h0006};
        vt[11] = '{1, 0,  1, 16'h0007, 1, 1, 0, 16'h3412};
        vt[12] = '{1, 0,  6, 16'h0008, 1, 1, 0, 16'h8000};
        vt[13] = '{1, 1,  8, 16'h0009, 1, 1, 0, 16'h4000};
        vt[14] = '{1, 0, 15, 16'h0009, 0, 0, 1, 16'h0009};
        vt[15] = '{1, 1,  0, 16'h0009, 0, 0, 1, 16'h0000};
        vt[16] = '{1, 0,  8, 16'h0009, 1, 0, 0, 16'h4000};
        vt[17] = '{0, 0,  7, 16'h000A, 1, 1, 0, 16'h0000};
        vt[18] = '{0, 0,  7, 16'h000A, 1, 0, 0, 16'hB412};
        vt[19] = '{0, 0, 15, 16'h000A, 1, 0, 0, 16'h000A};
        vt[20] = '{1, 0,  9, 16'h000A, 1, 0, 0, 16'h0000};
        vt[21] = '{1, 1,  7, 16'h000B, 1, 1, 0, 16'hB412};
        vt[22] = '{0, 0,  9, 16'h000C, 1, 1, 0, 16'h8000};
        vt[23] = '{0, 0,  8, 16'h000C, 1, 0, 0, 16'hE5F7};

        clear     = 1'b1;
        ins_valid = 1'b0;
        resume    = 1'b0;
        dbg_sel   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", -1, 16'(ins_req), 16'h0);
        chk("rst_addr", -1, ins_addr, 16'h0000);
        chk("rst_halt", -1, 16'(halted), 16'h0);
        chk("rst_ret", -1, 16'(retire), 16'h0);
        clear = 1'b0;

        for (int i = 0; i < 24; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            ins_valid = vt[i].v;
            resume    = vt[i].rs;
            dbg_sel   = vt[i].sel;
            #1;
            chk("addr", i, ins_addr, vt[i].addr);
            chk("req", i, 16'(ins_req), 16'(vt[i].req));
            chk("retire", i, 16'(retire), 16'(vt[i].ret));
            chk("halted", i, 16'(halted), 16'(vt[i].hlt));
            chk("dbg", i, dbg_data, vt[i].dbg);
        end

        // clear while a fetch is waiting, then restart from reset pc
        clear = 1'b1;
        #1;
        chk("clr_req", 100, 16'(ins_req), 16'h0);
        chk("clr_addr", 100, ins_addr, 16'h0000);
        dbg_sel = 4'd8;
        #1;
        chk("clr_r8", 100, dbg_data, 16'h0000);
        dbg_sel = 4'd1;
        #1;
        chk("clr_r1", 100, dbg_data, 16'h0000);
        ins_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_hold_req", 101, 16'(ins_req), 16'h0);
        chk("clr_hold_ret", 101, 16'(retire), 16'h0);
        clear = 1'b0;
        #1;
        chk("rel_req", 101, 16'(ins_req), 16'h1);
        @(posedge clk);
        #1;
        chk("rel_ret", 102, 16'(retire), 16'h1);
        chk("rel_addr", 102, ins_addr, 16'h0001);
        @(posedge clk);
        #1;
        chk("rel_r1", 103, dbg_data, 16'h0012);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
